// File: rtl/aeb_window_gain_pkg.sv
// aeb_pkg: shared types and helpers for the AEB window/gain block.
//  GAIN_FRAC   fractional bits of the exposure gain (0x100 = 1.0)
//  aeb_state_e control FSM states
//  sat8        saturate a signed value to 8 bits
//  clampu      clamp a value into [lo, hi]
//  recip_hp    round(2^frac / n), evaluated at elaboration time only
package aeb_pkg;

  localparam int GAIN_FRAC = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, MULT, UPDATE} aeb_state_e;

  function automatic logic signed [7:0] sat8(input int v);
    if (v > 127)  return 8'sd127;
    if (v < -128) return 8'sh80;
    return 8'(v);
  endfunction

  function automatic int clampu(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic longint unsigned recip_hp(input int frac, input longint unsigned n);
    return ((64'd1 << frac) + n / 2) / n;
  endfunction

endpackage

// File: rtl/aeb_window_gain_if.sv
// Pixel stream into the AEB block.
//  pix_sof    first pixel of frame (qualified by pix_valid & pix_ready)
//  pix_valid  beat valid
//  pix_ready  block accepts beat
//  pix_data   NCH channels of PW bits, channel 0 in the LSBs
// master = upstream pixel source, slave = AEB block.
interface aeb_window_gain_if #(
  parameter int NCH = 3,
  parameter int PW  = 8
);
  logic                    pix_sof;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [NCH-1:0][PW-1:0]  pix_data;

  modport master (output pix_sof, pix_valid, pix_data, input  pix_ready);
  modport slave  (input  pix_sof, pix_valid, pix_data, output pix_ready);
endinterface

// File: rtl/aeb_window_acc.sv
// Window accumulator: tracks x/y of each counted beat, sums all channels of
// pixels inside the crop window and flags the last pixel of the frame.
//  clk, reset  clock, async active-low reset
//  beat        counted beat this cycle (sof beat or beat inside a frame)
//  start       this beat carries sof: it is pixel (0,0) and restarts acc
//  data        pixel channels
//  acc         running window sum
//  frame_done  this beat is the last pixel of the frame
module aeb_window_acc #(
  parameter int NCH     = 3,
  parameter int PW      = 8,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int X0      = 0,
  parameter int Y0      = 0,
  parameter int WC      = 640,
  parameter int HC      = 480,
  parameter int ACC_W   = PW + $clog2(NCH*WC*HC+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   beat,
  input  logic                   start,
  input  logic [NCH-1:0][PW-1:0] data,
  output logic [ACC_W-1:0]       acc,
  output logic                   frame_done
);

  localparam int XW  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int YW  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int CSW = PW + $clog2(NCH+1);

  logic [XW-1:0]  x_q, cur_x;
  logic [YW-1:0]  y_q, cur_y;
  logic [CSW-1:0] csum;
  logic           in_win, last_px, eol;

  // A sof beat is always (0,0) regardless of where the counters stood.
  assign cur_x = start ? '0 : x_q;
  assign cur_y = start ? '0 : y_q;

  assign in_win  = (int'(cur_x) >= X0) && (int'(cur_x) < X0 + WC) &&
                   (int'(cur_y) >= Y0) && (int'(cur_y) < Y0 + HC);
  assign eol     = int'(cur_x) == FRAME_W - 1;
  assign last_px = eol && (int'(cur_y) == FRAME_H - 1);
  assign frame_done = beat && last_px;

  always_comb begin
    csum = '0;
    for (int c = 0; c < NCH; c++) csum = csum + CSW'(data[c]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      acc <= '0;
    end else if (beat) begin
      acc <= (start ? '0 : acc) + (in_win ? ACC_W'(csum) : '0);
      if (last_px) begin
        x_q <= '0;
        y_q <= '0;
      end else if (eol) begin
        x_q <= '0;
        y_q <= cur_y + YW'(1);
      end else begin
        x_q <= cur_x + XW'(1);
        y_q <= cur_y;
      end
    end
  end

endmodule

// File: rtl/aeb_window_gain.sv
// Auto-exposure/brightness control: window mean via reciprocal multiply,
// signed brightness error and a saturated exposure gain loop.
//  clk, reset   clock, async active-low reset
//  enable       0 freezes gain; mean/err still update
//  target       target mean brightness
//  pix          pixel stream (slave side)
//  mean         last frame window mean
//  err          sat8(target - mean)
//  gain         exposure gain, GAIN_FRAC fractional bits
//  gain_valid   one-cycle pulse when mean/err/gain update
//  sof_missing  sticky: beat seen in IDLE without sof, cleared by next sof
module aeb_window_gain
  import aeb_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int PW        = 8,
  parameter int FRAME_W   = 640,
  parameter int FRAME_H   = 480,
  parameter int X0        = 0,
  parameter int Y0        = 0,
  parameter int WC        = 640,
  parameter int HC        = 480,
  parameter int HP_FRAC   = 32,
  parameter int GW        = 12,
  parameter int GAIN_INIT = 1 << GAIN_FRAC,
  parameter int GAIN_MIN  = 'h040,
  parameter int GAIN_MAX  = 'hFFF,
  parameter int KP        = 4,
  parameter int KP_FRAC   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PW-1:0]       target,
  aeb_window_gain_if.slave    pix,
  output logic [PW-1:0]       mean,
  output logic signed [7:0]   err,
  output logic [GW-1:0]       gain,
  output logic                gain_valid,
  output logic                sof_missing
);

  localparam int NPIX  = NCH * WC * HC;
  localparam int ACC_W = PW + $clog2(NPIX + 1);
  localparam int PRW   = ACC_W + HP_FRAC + 1;
  localparam logic [HP_FRAC:0] RECIP = (HP_FRAC+1)'(recip_hp(HP_FRAC, longint'(NPIX)));

  aeb_state_e         state;
  logic               rdy_en;
  logic               accept, start, beat, frame_done;
  logic [ACC_W-1:0]   acc;
  logic [PRW-1:0]     prod, rnd, q;
  logic [PW-1:0]      mean_nxt;
  logic signed [PW:0] e;
  logic signed [7:0]  err_nxt;
  logic signed [GW+8:0] dlt, gsum;
  logic [GW-1:0]      gain_nxt;

  // Ready is held off for the first cycle out of reset.
  assign pix.pix_ready = rdy_en && (state == IDLE || state == ACCUM);
  assign accept = pix.pix_valid && pix.pix_ready;
  assign start  = accept && pix.pix_sof;
  // Beats in IDLE without sof are not part of any frame.
  assign beat   = accept && (pix.pix_sof || state == ACCUM);

  aeb_window_acc #(
    .NCH(NCH), .PW(PW), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .X0(X0), .Y0(Y0), .WC(WC), .HC(HC), .ACC_W(ACC_W)
  ) u_acc (
    .clk(clk), .reset(reset), .beat(beat), .start(start),
    .data(pix.pix_data), .acc(acc), .frame_done(frame_done)
  );

  // mean = round_half_up(acc / NPIX), via fixed-point reciprocal.
  always_comb begin
    prod     = PRW'(acc) * PRW'(RECIP);
    rnd      = prod + (PRW'(1) << (HP_FRAC - 1));
    q        = rnd >> HP_FRAC;
    mean_nxt = (q > PRW'(2**PW - 1)) ? '1 : q[PW-1:0];
  end

  // Gain step uses the error being registered this cycle, not the old err.
  always_comb begin
    e        = $signed({1'b0, target}) - $signed({1'b0, mean});
    err_nxt  = sat8(int'(e));
    dlt      = (GW+9)'((int'(err_nxt) * KP) >>> KP_FRAC);
    gsum     = $signed({9'b0, gain}) + dlt;
    gain_nxt = GW'(clampu(int'(gsum), GAIN_MIN, GAIN_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rdy_en      <= 1'b0;
      mean        <= '0;
      err         <= '0;
      gain        <= GW'(GAIN_INIT);
      gain_valid  <= 1'b0;
      sof_missing <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      gain_valid <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (start)
            sof_missing <= 1'b0;
          else if (accept && state == IDLE)
            sof_missing <= 1'b1;
          // sof inside ACCUM simply restarts the frame: acc restarts in u_acc.
          if (frame_done)
            state <= MULT;
          else if (start)
            state <= ACCUM;
        end
        MULT: begin
          mean  <= mean_nxt;
          state <= UPDATE;
        end
        UPDATE: begin
          err        <= err_nxt;
          if (enable) gain <= gain_nxt;
          gain_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aeb_window_gain.sv
// Randomized bench for aeb_window_gain on an 8x4 frame with a 4x2 window at (2,1).
module tb_aeb_window_gain;

  localparam int FW = 8, FH = 4, WX0 = 2, WY0 = 1, WW = 4, WH = 2;
  localparam int NP = WW * WH;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [7:0]        target = '0;
  logic [7:0]        mean;
  logic signed [7:0] err;
  logic [11:0]       gain;
  logic              gain_valid, sof_missing;

  aeb_window_gain_if #(.NCH(1), .PW(8)) pix ();

  aeb_window_gain #(
    .NCH(1), .PW(8), .FRAME_W(FW), .FRAME_H(FH),
    .X0(WX0), .Y0(WY0), .WC(WW), .HC(WH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .target(target), .pix(pix),
    .mean(mean), .err(err), .gain(gain), .gain_valid(gain_valid),
    .sof_missing(sof_missing)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int m; int e; int g; } gv_t;
  gv_t gvq[$];
  int  cyc = 0;
  int  rdy_low = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (gain_valid) gvq.push_back(gv_t'{cyc, int'(mean), int'(err), int'(gain)});
    if (!pix.pix_ready) rdy_low <= rdy_low + 1;
  end

  int n_vec = 0, n_bad = 0;
  int frame [FH][FW];
  int mgain = 256;
  int last_acc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain window average, rounded half up; floor-divided loop step.
  task automatic model(input int tgt, input bit en, output int m, output int e);
    int sum = 0, d;
    for (int y = WY0; y < WY0 + WH; y++)
      for (int x = WX0; x < WX0 + WW; x++) sum += frame[y][x];
    m = (2 * sum + NP) / (2 * NP);
    if (m > 255) m = 255;
    e = tgt - m;
    if (e > 127) e = 127;
    if (e < -128) e = -128;
    d = e * 4;
    d = (d >= 0) ? d / 16 : -((-d + 15) / 16);
    if (en) begin
      mgain = mgain + d;
      if (mgain < 'h40) mgain = 'h40;
      if (mgain > 'hFFF) mgain = 'hFFF;
    end
  endtask

  task automatic beat(input int d, input bit s, input bit gaps);
    int t = 0;
    if (gaps)
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clk); pix.pix_valid = 1'b0; pix.pix_sof = 1'b0;
      end
    @(negedge clk);
    pix.pix_valid = 1'b1; pix.pix_sof = s; pix.pix_data[0] = 8'(d);
    while (!pix.pix_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    last_acc = cyc;
  endtask

  task automatic idle();
    @(negedge clk); pix.pix_valid = 1'b0; pix.pix_sof = 1'b0;
  endtask

  task automatic drive(input bit gaps, input int nbeats);
    for (int i = 0; i < nbeats; i++) beat(frame[i / FW][i % FW], i == 0, gaps);
  endtask

  task automatic fill_rand();
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) frame[y][x] = int'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input string tag, input int tgt, input bit en, input bit gaps);
    int m, e, lc, t = 0;
    gv_t r;
    target = 8'(tgt); enable = en;
    drive(gaps, FW * FH);
    lc = last_acc;
    idle();
    model(tgt, en, m, e);
    while (gvq.size() == 0 && t < 10) begin @(negedge clk); #1; t++; end
    if (gvq.size() == 0) begin
      chk({tag, ".gv_timeout"}, 0, 1);
    end else begin
      r = gvq.pop_front();
      // Accepted at edge k; pulse visible between edges k+2 and k+3.
      chk({tag, ".latency"}, r.c - lc, 2);
      chk({tag, ".mean"}, r.m, m);
      chk({tag, ".err"}, r.e, e);
      chk({tag, ".gain"}, r.g, mgain);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    pix.pix_valid = 1'b0; pix.pix_sof = 1'b0; pix.pix_data = '0;
    repeat (2) @(negedge clk);
    chk("rst.mean", int'(mean), 0);
    chk("rst.gain", int'(gain), 256);
    chk("rst.gv", int'(gain_valid), 0);
    #2 reset = 1'b1;
    #1 chk("rst.ready_first", int'(pix.pix_ready), 0);
    @(posedge clk); #1;
    chk("rst.ready_after", int'(pix.pix_ready), 1);
    chk("rst.sof_missing", int'(sof_missing), 0);

    // Flat 200 frame.
    for (int i = 0; i < FW * FH; i++) frame[i / FW][i % FW] = 200;
    run_frame("flat200", 128, 1'b1, 1'b0);

    // 0 outside, 64 inside: window edges.
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        frame[y][x] = (x >= WX0 && x < WX0 + WW && y >= WY0 && y < WY0 + WH) ? 64 : 0;
    run_frame("win64", 128, 1'b1, 1'b0);

    // Saturated error drives gain to its floor.
    for (int i = 0; i < FW * FH; i++) frame[i / FW][i % FW] = 255;
    for (int n = 0; n < 8; n++) run_frame("sat", 0, 1'b1, 1'b0);
    chk("gain_min", int'(gain), 'h40);

    // Random enabled frames.
    for (int n = 0; n < 3; n++) begin
      fill_rand();
      run_frame("rand_en", int'($urandom_range(0, 255)), 1'b1, 1'b1);
    end

    // Abort at (5,2): the sof of the restarted frame lands on that beat.
    fill_rand();
    target = 8'd100; enable = 1'b1;
    drive(1'b0, 2 * FW + 5);
    fill_rand();
    run_frame("restart", 100, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("abort.extra_gv", gvq.size(), 0);

    // Reset mid-ACCUM.
    fill_rand();
    drive(1'b0, 10);
    @(negedge clk); #2;
    reset = 1'b0; pix.pix_valid = 1'b0; pix.pix_sof = 1'b0;
    #1;
    chk("mrst.mean", int'(mean), 0);
    chk("mrst.err", int'(err), 0);
    chk("mrst.gain", int'(gain), 256);
    chk("mrst.gv", int'(gain_valid), 0);
    chk("mrst.ready", int'(pix.pix_ready), 0);
    mgain = 256;
    @(negedge clk); #2 reset = 1'b1;

    // Beat without sof in IDLE.
    beat(55, 1'b0, 1'b0);
    idle();
    chk("sof_missing.set", int'(sof_missing), 1);
    chk("sof_missing.no_gv", gvq.size(), 0);
    fill_rand();
    run_frame("post_rst", 128, 1'b1, 1'b0);
    chk("sof_missing.clr", int'(sof_missing), 0);

    // Gain frozen, random valid gaps, ready low two cycles per frame.
    mgain = int'(gain);
    for (int n = 0; n < 3; n++) begin
      fill_rand();
      repeat (2) @(negedge clk);
      base = rdy_low;
      run_frame("frozen", int'($urandom_range(0, 255)), 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("frozen.ready_low", rdy_low - base, 2);
      chk("frozen.gain", int'(gain), mgain);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
